// File: rtl/fifo_ptr_ctrl.sv
// Pointer, flag and error controller for a single-clock FIFO of 2^ADDR_W entries.
// Full/empty come from (ADDR_W+1)-bit wrap-extended pointer comparison; a small FSM shadows them.
module fifo_ptr_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clr_err,
    output logic              mem_we,
    output logic              rd_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PtrW  = ADDR_W + 1;
    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    state_e          state_q, state_d;
    logic            fsm_empty, fsm_full;
    logic            wr_acc, rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    // Acceptance is blocked during flush and while reset is held so strobes read as idle.
    assign wr_acc = wr_en & ~full & ~flush & rst_n;
    assign rd_acc = rd_en & ~empty & ~flush & rst_n;

    assign mem_we       = wr_acc;
    assign rd_ack       = rd_acc;
    assign wr_addr      = wr_ptr_q[ADDR_W-1:0];
    assign rd_addr      = rd_ptr_q[ADDR_W-1:0];
    assign count        = count_q;
    assign almost_full  = (count_q >= PtrW'(AF_LEVEL));
    assign almost_empty = (count_q <= PtrW'(AE_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PtrW'(1);
                2'b01:   count_d = count_q - PtrW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A fresh error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full)  overflow_d  = 1'b1;
        if (rd_en && empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (wr_acc) state_d = StActive;
                end
                StActive: begin
                    if (count_q == PtrW'(Depth - 1) && wr_acc && !rd_acc) begin
                        state_d = StFull;
                    end else if (count_q == PtrW'(1) && rd_acc && !wr_acc) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (rd_acc) state_d = StActive;
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        fsm_empty = (state_q == StEmpty);
        fsm_full  = (state_q == StFull);
    end

    fsm_flags_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (fsm_empty == empty) && (fsm_full == full));

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: occupancy model checked every cycle plus literal pins.
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en, flush, clr_err;
    logic       mem_we, rd_ack, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] wr_addr, rd_addr;
    logic [4:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Reference model: occupancy plus free-running 5-bit pointer values as plain integers.
    int m_cnt, m_wr, m_rd;
    bit m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
        .clr_err(clr_err), .mem_we(mem_we), .rd_ack(rd_ack), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
        .underflow(underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_wacc();
        return wr_en && (m_cnt < 16) && !flush;
    endfunction

    function automatic bit m_racc();
        return rd_en && (m_cnt > 0) && !flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_wr <= 0; m_rd <= 0; m_ovf <= 1'b0; m_unf <= 1'b0;
        end else begin
            if (flush) begin
                m_cnt <= 0; m_wr <= 0; m_rd <= 0;
            end else begin
                m_cnt <= m_cnt + int'(m_wacc()) - int'(m_racc());
                m_wr  <= (m_wr + int'(m_wacc())) % 32;
                m_rd  <= (m_rd + int'(m_racc())) % 32;
            end
            m_ovf <= (wr_en && m_cnt == 16) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_unf <= (rd_en && m_cnt == 0)  ? 1'b1 : (clr_err ? 1'b0 : m_unf);
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m_count",   count,        m_cnt);
            chk("m_full",    full,         m_cnt == 16);
            chk("m_empty",   empty,        m_cnt == 0);
            chk("m_afull",   almost_full,  m_cnt >= 12);
            chk("m_aempty",  almost_empty, m_cnt <= 4);
            chk("m_mem_we",  mem_we,       m_wacc());
            chk("m_rd_ack",  rd_ack,       m_racc());
            chk("m_wr_addr", wr_addr,      m_wr % 16);
            chk("m_rd_addr", rd_addr,      m_rd % 16);
            chk("m_ovf",     overflow,     m_ovf);
            chk("m_unf",     underflow,    m_unf);
        end
    end

    task automatic drive(input bit w, input bit r, input bit f, input bit c);
        wr_en = w; rd_en = r; flush = f; clr_err = c;
    endtask

    // Apply inputs for one clock and return 1 time unit after the edge.
    task automatic step(input bit w, input bit r, input bit f, input bit c);
        drive(w, r, f, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1'b1;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_aempty", almost_empty, 1);

        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0);
            if (i == 11) chk("afull_at_11", almost_full, 0);
            if (i == 12) chk("afull_at_12", almost_full, 1);
        end
        drive(0, 0, 0, 0); #1;
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_wr_ptr", dut.wr_ptr_q, 5'b10000);
        chk("fill_rd_ptr", dut.rd_ptr_q, 0);

        drive(1, 0, 0, 0); #1;
        chk("w17_mem_we", mem_we, 0);
        step(1, 0, 0, 0);
        chk("w17_overflow", overflow, 1);

        drive(1, 1, 0, 0); #1;
        chk("fullrw_rd_ack", rd_ack, 1);
        chk("fullrw_mem_we", mem_we, 0);
        step(1, 1, 0, 0);
        chk("fullrw_count", count, 15);
        chk("fullrw_full", full, 0);
        step(0, 0, 0, 1);
        chk("clr_overflow", overflow, 0);

        for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
        drive(0, 0, 0, 0); #1;
        chk("drain_empty", empty, 1);
        drive(0, 1, 0, 0); #1;
        chk("emptyrd_rd_ack", rd_ack, 0);
        step(0, 1, 0, 0);
        chk("emptyrd_underflow", underflow, 1);
        drive(1, 1, 0, 0); #1;
        chk("emptyrw_mem_we", mem_we, 1);
        chk("emptyrw_rd_ack", rd_ack, 0);
        step(1, 1, 0, 0);
        chk("emptyrw_count", count, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);

        // Pointers start at 17 here; 40 pairs carry them past 31 back through 0.
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0);
            step(0, 1, 0, 0);
            chk("wrap_empty", empty, 1);
            chk("wrap_full", full, 0);
        end
        drive(0, 0, 0, 0); #1;
        chk("wrap_wr_addr", wr_addr, 9);
        chk("wrap_rd_addr", rd_addr, 9);

        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        drive(1, 0, 1, 0); #1;
        chk("flush_mem_we", mem_we, 0);
        step(1, 0, 1, 0);
        drive(0, 0, 0, 0); #1;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_aempty", almost_empty, 1);
        chk("arst_afull", almost_full, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_rd_ack", rd_ack, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_rd_addr", rd_addr, 0);
        chk("arst_ovf", overflow, 0);
        drive(0, 0, 0, 0);
        #10 rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
